// File: rtl/imem_arbiter_pkg.sv
// Shared constants for the text-memory arbiter: legal word-address windows,
// state encodings and the range helper used by the address checker.
package imem_arbiter_pkg;

  localparam logic [29:0] TEXT_DAT_BOT = 30'h0000_0400;
  localparam logic [29:0] TEXT_DAT_TOP = 30'h0000_07FF;
  localparam logic [29:0] IVT_BOT      = 30'h0000_0020;
  localparam logic [29:0] IVT_TOP      = 30'h0000_003F;

  typedef enum logic [1:0] {
    IMEM_IDLE  = 2'd0,
    IMEM_WAIT  = 2'd1,
    IMEM_FAULT = 2'd2
  } imem_state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } imem_owner_e;

  function automatic logic in_window(logic [29:0] word, logic [29:0] lo, logic [29:0] hi);
    return (word >= lo) && (word <= hi);
  endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Combinational legality check of a byte address against the .text data and
// interrupt-vector windows of the text memory.
module imem_addr_check
  import imem_arbiter_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic        legal_o,
  output logic        misaligned_o,
  output logic        out_of_range_o
);

  logic [29:0] word;

  assign word           = addr_i[31:2];
  assign misaligned_o   = |addr_i[1:0];
  assign out_of_range_o = !(in_window(word, TEXT_DAT_BOT, TEXT_DAT_TOP) ||
                            in_window(word, IVT_BOT, IVT_TOP));
  assign legal_o        = !misaligned_o && !out_of_range_o;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single text-memory read port between fetch (F) and data (D)
// requesters; D has priority except when F has been starved for too long.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_rdata,
  output logic        f_fault,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [3:0] LAT_LAST   = 4'(LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  imem_state_e state_q, state_d;
  imem_owner_e owner_q, owner_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  starve_q, starve_d;

  logic        f_legal, f_mis, f_oor;
  logic        d_legal, d_mis, d_oor;
  logic        pick_f, win_legal;
  logic [31:0] sel_addr;

  imem_addr_check u_f_check (
    .addr_i        (f_addr),
    .legal_o       (f_legal),
    .misaligned_o  (f_mis),
    .out_of_range_o(f_oor)
  );

  imem_addr_check u_d_check (
    .addr_i        (d_addr),
    .legal_o       (d_legal),
    .misaligned_o  (d_mis),
    .out_of_range_o(d_oor)
  );

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    starve_d  = starve_q;
    pick_f    = 1'b0;
    win_legal = 1'b0;
    sel_addr  = '0;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    f_valid   = 1'b0;
    d_valid   = 1'b0;
    f_rdata   = '0;
    d_rdata   = '0;
    f_fault   = 1'b0;
    d_fault   = 1'b0;
    mem_en    = 1'b0;
    mem_addr  = '0;

    unique case (state_q)
      IMEM_IDLE: begin
        // Grants are suppressed while reset is held so outputs stay quiet.
        if (!reset && (f_req || d_req)) begin
          pick_f    = f_req && (!d_req || (starve_q == STARVE_MAX));
          sel_addr  = pick_f ? f_addr : d_addr;
          win_legal = pick_f ? f_legal : d_legal;
          f_gnt     = pick_f;
          d_gnt     = !pick_f;
          mem_en    = win_legal;
          mem_addr  = {2'b00, sel_addr[31:2]};
          owner_d   = pick_f ? OWN_F : OWN_D;
          lat_cnt_d = 4'd1;
          state_d   = win_legal ? IMEM_WAIT : IMEM_FAULT;
        end
      end
      IMEM_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          f_valid = (owner_q == OWN_F);
          d_valid = (owner_q == OWN_D);
          f_rdata = f_valid ? mem_rdata : '0;
          d_rdata = d_valid ? mem_rdata : '0;
          state_d = IMEM_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      IMEM_FAULT: begin
        f_valid = (owner_q == OWN_F);
        d_valid = (owner_q == OWN_D);
        f_fault = f_valid;
        d_fault = d_valid;
        state_d = IMEM_IDLE;
      end
      default: state_d = IMEM_IDLE;
    endcase

    if (!f_req || f_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IMEM_IDLE;
      owner_q   <= OWN_F;
      lat_cnt_q <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      starve_q  <= starve_d;
    end
  end

  assign busy = (state_q != IMEM_IDLE);

  always_comb begin
    assert (f_legal == !(f_mis || f_oor));
    assert (d_legal == !(d_mis || d_oor));
    assert (!(f_gnt && d_gnt));
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single read port of the instruction/text memory between two requesters: the fetch stage (F) and a data-side read port (D) for constants and jump tables in .text/.ivt.
- Owns the memory address/enable, sequences a fixed-latency read, and returns data to the winner. Illegal addresses are rejected before they reach memory.
- Sits between the fetch stage / memory stage and the text memory.

Parameters:
- LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..8.
- STARVE_LIMIT, 4, consecutive D grants allowed while F is waiting before F is forced to win; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held until f_gnt.
- f_addr  in  32  fetch byte address; stable while f_req is high.
- f_gnt  out  1  one-cycle pulse; F request accepted.
- f_valid  out  1  one-cycle pulse; f_rdata/f_fault valid.
- f_rdata  out  32  fetch read data.
- f_fault  out  1  fetch address misaligned or out of range; qualified by f_valid.
- d_req, d_addr, d_gnt, d_valid, d_rdata, d_fault: same as the F ports, for the data requester.
- mem_en  out  1  memory read strobe, one cycle per access.
- mem_addr  out  32  word address (byte address >> 2).
- mem_rdata  in  32  memory data; valid LATENCY cycles after mem_en; held until the next mem_en.
- busy  out  1  transaction outstanding (state != IDLE).

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0. Reset mid-transaction drops the transaction, and no valid is ever issued for it.
- States:
  - IDLE → WAIT on an accepted legal request.
  - IDLE → FAULT on an accepted illegal request.
  - WAIT → IDLE after the response cycle.
  - FAULT → IDLE after one cycle.
- Grant happens only in IDLE, in the same cycle as the request.
  - gnt pulse, mem_en=1 and mem_addr=addr>>2 are all asserted combinationally in the grant cycle.
  - The owner and address are latched at the grant edge.
- Winner selection: D has priority, unless the starvation counter equals STARVE_LIMIT and f_req=1, in which case F wins.
- Starvation counter:
  - Increments on a D grant while f_req=1, saturating at STARVE_LIMIT.
  - Clears on any F grant, or in any cycle with f_req=0.
- Legal-address check, against the shared constants:
  - addr[1:0]==0, and
  - word address is in [TEXT_DAT_BOT,TEXT_DAT_TOP] or in [IVT_BOT,IVT_TOP].
  - An illegal request is still granted, but mem_en stays 0.
- Response timing:
  - Legal access: the owner's valid pulses exactly LATENCY cycles after the grant cycle. rdata = mem_rdata and fault=0 in that cycle.
  - Illegal access: valid and fault pulse 1 cycle after the grant cycle, with rdata=0.
  - Outside valid, rdata reads 0 and fault reads 0.
- Throughput: the next grant is no earlier than the cycle after valid, so the minimum spacing is LATENCY+1 cycles. mem_en is never asserted while busy=1.
- Requests:
  - A request arriving while busy waits; it is not lost.
  - f_req and d_req may both be high; exactly one gnt is asserted per grant cycle, never both.
  - Dropping req before gnt is permitted and cancels the request.
- Only the owner's valid pulses; the other requester's valid/fault stay 0.

Decomposition:
- Shared header (mips.h): TEXT_DAT_BOT, TEXT_DAT_TOP, IVT_BOT, IVT_TOP, and the state encodings IMEM_IDLE/IMEM_WAIT/IMEM_FAULT.
- Sub-module imem_addr_check: purely combinational, byte address in, legal/misaligned/out_of_range out.
  - Instantiated twice, once per requester.
  - Reused by the fetch stage for diagnostics.

Test Plan:
- LATENCY=1; f_req with f_addr=TEXT_DAT_BOT*4, memory returning 0x2402_0005 → f_gnt and mem_en in cycle 0, mem_addr=TEXT_DAT_BOT, f_valid in cycle 1 with f_rdata=0x2402_0005, f_fault=0.
- LATENCY=3; f_req and d_req raised together in cycle 0 → d_gnt in cycle 0 and d_valid in cycle 3. f_gnt in cycle 4 and f_valid in cycle 7. f_valid and d_valid are never high together.
- STARVE_LIMIT=2; d_req held continuously with f_req high → D granted twice, then F granted on the third grant slot, then D resumes.
- d_addr=TEXT_DAT_BOT*4+2 (misaligned) → d_gnt, mem_en stays 0, d_valid=d_fault=1 one cycle later, d_rdata=0. Repeat with the word address at IVT_TOP+1 → same response.
- Reset asserted in WAIT (LATENCY=4, cycle 2 after grant), released 2 cycles later → no f_valid ever issued for the dropped access. All outputs read 0 during reset. A new f_req is granted in the first cycle after release.
- Back-to-back F requests at addresses 0x...00, 0x...04, 0x...08 with LATENCY=1 → grants in cycles 0, 2 and 4; data returned in order.
